// File: rtl/alu181_seq_engine.sv
// Slice-serial 74181 ALU: one 4-bit slice per clock, LSB first, registered inter-slice carry.
// Optional 7-segment scan of the result nibbles is built when ALU181_SEG_SCAN_EN is defined.
module alu181_seq_engine #(
    parameter int unsigned NUM_SLICES = 2,
    parameter int unsigned SCAN_DIV   = 16,
    localparam int unsigned WIDTH     = 4 * NUM_SLICES,
    localparam int unsigned DSEL_W    = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [3:0]        s,
    input  logic              m,
    input  logic              ci,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  f,
    output logic              co,
    output logic              eq,
    output logic [7:0]        seg,
    output logic [DSEL_W-1:0] dig_sel
);

    localparam int unsigned CNT_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_SLICES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, f_q, f_d;
    logic [3:0]       s_q;
    logic             m_q, cy_q, co_q, eq_q, out_valid_q, in_ready_q;
    logic [CNT_W-1:0] cnt_q;

    logic [3:0] na, nb, nf, x, y;
    logic [4:0] sum;
    logic       ncy;

    always_comb begin
        na  = a_q[{cnt_q, 2'b00} +: 4];
        nb  = b_q[{cnt_q, 2'b00} +: 4];
        x   = '0;
        y   = '0;
        sum = '0;
        nf  = '0;
        ncy = 1'b0;
        if (m_q) begin
            case (s_q)
                4'h0: nf = ~na;
                4'h1: nf = ~(na | nb);
                4'h2: nf = ~na & nb;
                4'h3: nf = '0;
                4'h4: nf = ~(na & nb);
                4'h5: nf = ~nb;
                4'h6: nf = na ^ nb;
                4'h7: nf = na & ~nb;
                4'h8: nf = ~na | nb;
                4'h9: nf = ~(na ^ nb);
                4'hA: nf = nb;
                4'hB: nf = na & nb;
                4'hC: nf = '1;
                4'hD: nf = na | ~nb;
                4'hE: nf = na | nb;
                default: nf = na;
            endcase
        end else begin
            case (s_q)
                4'h0: begin x = na;        y = '0;        end
                4'h1: begin x = na | nb;   y = '0;        end
                4'h2: begin x = na | ~nb;  y = '0;        end
                4'h3: begin x = '0;        y = '1;        end
                4'h4: begin x = na;        y = na & ~nb;  end
                4'h5: begin x = na | nb;   y = na & ~nb;  end
                4'h6: begin x = na;        y = ~nb;       end
                4'h7: begin x = na & ~nb;  y = '1;        end
                4'h8: begin x = na;        y = na & nb;   end
                4'h9: begin x = na;        y = nb;        end
                4'hA: begin x = na | ~nb;  y = na & nb;   end
                4'hB: begin x = na & nb;   y = '1;        end
                4'hC: begin x = na;        y = na;        end
                4'hD: begin x = na | nb;   y = na;        end
                4'hE: begin x = na | ~nb;  y = na;        end
                default: begin x = na;     y = '1;        end
            endcase
            sum = {1'b0, x} + {1'b0, y} + {4'b0000, cy_q};
            nf  = sum[3:0];
            ncy = sum[4];
        end
        f_d = f_q;
        f_d[{cnt_q, 2'b00} +: 4] = nf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            m_q         <= 1'b0;
            f_q         <= '0;
            co_q        <= 1'b0;
            eq_q        <= 1'b0;
            cy_q        <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        s_q        <= s;
                        m_q        <= m;
                        cy_q       <= ci;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    f_q  <= f_d;
                    cy_q <= ncy;
                    // co/eq only update on the final slice so they stay put until the result is complete
                    if (cnt_q == LAST) begin
                        cnt_q       <= '0;
                        co_q        <= ncy;
                        eq_q        <= &f_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign f         = f_q;
    assign co        = co_q;
    assign eq        = eq_q;

`ifdef ALU181_SEG_SCAN_EN
    localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    function automatic logic [7:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 8'h3F;
            4'h1: hex7 = 8'h06;
            4'h2: hex7 = 8'h5B;
            4'h3: hex7 = 8'h4F;
            4'h4: hex7 = 8'h66;
            4'h5: hex7 = 8'h6D;
            4'h6: hex7 = 8'h7D;
            4'h7: hex7 = 8'h07;
            4'h8: hex7 = 8'h7F;
            4'h9: hex7 = 8'h6F;
            4'hA: hex7 = 8'h77;
            4'hB: hex7 = 8'h7C;
            4'hC: hex7 = 8'h39;
            4'hD: hex7 = 8'h5E;
            4'hE: hex7 = 8'h79;
            default: hex7 = 8'h71;
        endcase
    endfunction

    logic [PRE_W-1:0]  pre_q;
    logic              pre_wrap;
    logic [DSEL_W-1:0] dig_sel_q, dig_sel_d;
    logic [7:0]        seg_q;

    always_comb begin
        pre_wrap  = (pre_q == PRE_W'(SCAN_DIV - 1));
        dig_sel_d = dig_sel_q;
        if (pre_wrap) begin
            dig_sel_d = (dig_sel_q == DSEL_W'(NUM_SLICES - 1)) ? '0 : dig_sel_q + DSEL_W'(1);
        end
    end

    // seg is decoded against the digit index being loaded so both registers change on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q     <= '0;
            dig_sel_q <= '0;
            seg_q     <= '0;
        end else begin
            pre_q     <= pre_wrap ? '0 : pre_q + PRE_W'(1);
            dig_sel_q <= dig_sel_d;
            seg_q     <= hex7(f_q[{dig_sel_d, 2'b00} +: 4]);
        end
    end

    assign seg     = seg_q;
    assign dig_sel = dig_sel_q;
`else
    assign seg     = '0;
    assign dig_sel = '0;
`endif

endmodule

// File: doc/alu181_seq_engine.md
Name: alu181_seq_engine

Overview:
- Parametrised, slice-serial successor to the fixed two-slice 8-bit 74181 datapath.
- Evaluates one 4-bit 74181-function slice per clock over a WIDTH = 4*NUM_SLICES word, LSB slice first, with a registered inter-slice carry.
- Operands enter and results leave through valid/ready handshakes, so the block can sit behind the SPI register file or any other sequencer.
- Optionally drives a time-multiplexed 7-segment scan of the result nibbles.

Parameters:
- NUM_SLICES, 2, number of 4-bit slices (>=1); WIDTH = 4*NUM_SLICES (localparam).
- SCAN_DIV, 16, cycles per digit in the 7-seg scan (>=1; used only with the optional feature).

Ports:
- clk  in  1  clock; single domain.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  engine can accept an operation.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- s  in  4  74181 function select.
- m  in  1  1 = logic mode, 0 = arithmetic mode.
- ci  in  1  carry in, active-high (1 adds one).
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- f  out  WIDTH  result.
- co  out  1  carry out of the MSB slice.
- eq  out  1  A=B flag: f is all ones.
- seg  out  8  {dp,g,f,e,d,c,b,a}, active-high (optional feature only).
- dig_sel  out  DSEL_W  displayed nibble index; DSEL_W = max(1, clog2(NUM_SLICES)) (optional feature only).

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset:
  - State goes to IDLE.
  - f=0, co=0, eq=0, out_valid=0.
  - Slice counter, carry register, seg and dig_sel are all 0.
  - Applies in any state, including mid-RUN; the partial result is discarded.
- FSM states: IDLE, RUN, DONE.
- in_ready = (state == IDLE).
- IDLE:
  - On in_valid, capture a, b, s, m and ci into internal registers.
  - Load the carry register from ci; set the counter to 0; go to RUN.
- RUN, each cycle, for slice k = counter:
  - Take nibbles A = a[4k+3:4k] and B = b[4k+3:4k].
  - Write F to f[4k+3:4k].
  - Update the carry register with the slice carry out.
  - Increment the counter.
  - At counter = NUM_SLICES-1, go to DONE.
  - in_valid is ignored throughout RUN.
- DONE:
  - out_valid=1; f, co and eq are held stable.
  - On out_ready, go to IDLE.
  - A new operation is accepted no earlier than the cycle after the out_ready handshake.
- Latency: out_valid rises exactly NUM_SLICES cycles after the accepting edge.
- After completion, f, co and eq keep their last values in IDLE. During RUN they are undefined for the consumer.
- Logic mode (m=1), per bit:
  - 0: ~A
  - 1: ~(A|B)
  - 2: ~A&B
  - 3: 0
  - 4: ~(A&B)
  - 5: ~B
  - 6: A^B
  - 7: A&~B
  - 8: ~A|B
  - 9: ~(A^B)
  - A: B
  - B: A&B
  - C: 1
  - D: A|~B
  - E: A|B
  - F: A
  - Carries are ignored; co=0.
- Arithmetic mode (m=0): F = X + Y + c, where c is the carry register. Slice carry out = bit 4 of the 5-bit sum. X, Y per select:
  - 0: A, 0
  - 1: A|B, 0
  - 2: A|~B, 0
  - 3: 0, 1111
  - 4: A, A&~B
  - 5: A|B, A&~B
  - 6: A, ~B
  - 7: A&~B, 1111
  - 8: A, A&B
  - 9: A, B
  - A: A|~B, A&B
  - B: A&B, 1111
  - C: A, A
  - D: A|B, A
  - E: A|~B, A
  - F: A, 1111
- co = carry out of slice NUM_SLICES-1 (0 in logic mode).
- eq = AND over slices of (F == 4'hF).
- NUM_SLICES=1: RUN lasts one cycle; the counter never wraps.

Optional Feature:
- Macro: ALU181_SEG_SCAN_EN.
- Defined:
  - A free-running prescaler advances dig_sel every SCAN_DIV cycles, 0..NUM_SLICES-1 with wrap.
  - seg = hex 7-seg code of f nibble dig_sel, dp=0. Examples: 0→0x3F, 1→0x06, 5→0x6D, F→0x71.
  - Counts in all states; reset clears the prescaler and dig_sel.
- Undefined: seg and dig_sel are tied 0 and no scan logic is built.

Test Plan:
- NUM_SLICES=2, a=0x3C, b=0x15, s=9, m=0, ci=0 → out_valid 2 cycles after accept; f=0x51, co=0, eq=0. With the feature: dig_sel 0/1 every 16 cycles, seg 0x06 then 0x6D.
- a=0xFF, b=0x01, s=9, m=0, ci=0 → f=0x00, co=1 (inter-slice carry propagates). Same operands with ci=1 → f=0x01, co=1.
- a=0x5A, b=0x5A, s=6, m=0, ci=0 → f=0xFF, eq=1, co=0. Same with b=0x5B → f=0xFE, eq=0.
- a=0xF0, b=0xCC, s=6, m=1, ci=1 → f=0x3C, co=0. Then s=3, m=0, ci=1 → f=0x00, co=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE and pulse in_valid → in_ready=0, request ignored, f/co/eq stable. out_ready=1 → IDLE next cycle, in_ready=1.
- Assert rst for 1 cycle during RUN slice 0 → next cycle IDLE, out_valid=0, f=0, co=0; a following op (a=0x01, b=0x01, s=9) → f=0x02.
